// File: rtl/piano_play_scheduler.sv
// Piano note scheduler: arbitrates manual key play against a looping auto-play song ROM
// and issues one registered note request (code, octave, half-period) every cycle.
module piano_play_scheduler #(
    parameter int CLK_HZ      = 1_000_000,
    parameter int DEB_CYCLES  = 10_000,
    parameter int BEAT_CYCLES = 250_000,
    parameter int GAP_CYCLES  = 20_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  Switch,
    input  logic [6:0]  Key,
    output logic        Note_Valid,
    output logic [2:0]  Note_Code,
    output logic [1:0]  Octave,
    output logic [15:0] Half_Period,
    output logic [4:0]  Song_Idx,
    output logic        Note_Start,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MANUAL    = 2'd1,
        AUTO_PLAY = 2'd2,
        AUTO_GAP  = 2'd3
    } state_t;

    localparam int DW = $clog2(DEB_CYCLES + 1);

    state_t        state, state_n;
    logic [3:0]    sw_s1, sw_s2;
    logic [6:0]    key_s1, key_s2;
    logic [2:0]    cand, last_cand, acc;
    logic [DW-1:0] deb_cnt;
    logic [31:0]   tmr, tmr_n;
    logic [4:0]    idx_n, idx_inc;
    logic [7:0]    entry_n;
    logic [1:0]    man_oct, oct_n;
    logic [2:0]    code_n;
    logic [15:0]   hp_n;
    logic          start_n, valid_n;

    // Song entry = {oct, note, beats}; beats == 0 marks the end of the song.
    function automatic logic [7:0] rom_entry(input logic [4:0] i);
        case (i)
            5'd0:    return {2'd2, 3'd1, 3'd1};
            5'd1:    return {2'd2, 3'd1, 3'd1};
            5'd2:    return {2'd2, 3'd5, 3'd1};
            5'd3:    return {2'd2, 3'd5, 3'd1};
            5'd4:    return {2'd2, 3'd6, 3'd1};
            5'd5:    return {2'd2, 3'd6, 3'd1};
            5'd6:    return {2'd2, 3'd5, 3'd2};
            5'd7:    return {2'd2, 3'd4, 3'd1};
            5'd8:    return {2'd2, 3'd4, 3'd1};
            5'd9:    return {2'd2, 3'd3, 3'd1};
            5'd10:   return {2'd2, 3'd3, 3'd1};
            5'd11:   return {2'd2, 3'd2, 3'd1};
            5'd12:   return {2'd2, 3'd2, 3'd1};
            5'd13:   return {2'd2, 3'd1, 3'd2};
            default: return 8'd0;
        endcase
    endfunction

    // Mid-octave half-periods (C4..B4) from integer note frequencies.
    function automatic logic [15:0] mid_hp(input logic [2:0] code);
        case (code)
            3'd1:    return 16'(CLK_HZ / (2 * 262));
            3'd2:    return 16'(CLK_HZ / (2 * 294));
            3'd3:    return 16'(CLK_HZ / (2 * 330));
            3'd4:    return 16'(CLK_HZ / (2 * 349));
            3'd5:    return 16'(CLK_HZ / (2 * 392));
            3'd6:    return 16'(CLK_HZ / (2 * 440));
            3'd7:    return 16'(CLK_HZ / (2 * 494));
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] hp_for(input logic [2:0] code, input logic [1:0] oct);
        case (oct)
            2'd1:    return mid_hp(code) << 1;
            2'd2:    return mid_hp(code);
            2'd3:    return mid_hp(code) >> 1;
            default: return 16'd0;
        endcase
    endfunction

    // Timer reload for the sounding part of a note (counts down to 0).
    function automatic logic [31:0] play_len(input logic [2:0] beats);
        return {29'd0, beats} * 32'(BEAT_CYCLES) - 32'(GAP_CYCLES) - 32'd1;
    endfunction

    // Two-stage synchronizers for the asynchronous board inputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_s1  <= 4'd0;
            sw_s2  <= 4'd0;
            key_s1 <= 7'd0;
            key_s2 <= 7'd0;
        end else begin
            sw_s1  <= Switch;
            sw_s2  <= sw_s1;
            key_s1 <= Key;
            key_s2 <= key_s1;
        end
    end

    // Lowest note wins: scanning upward lets Key[6] (do) override the rest.
    always_comb begin
        cand = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (key_s2[i]) cand = 3'(7 - i);
        end
    end

    // Debounce: a candidate is accepted once it has been seen DEB_CYCLES cycles in a row.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_cand <= 3'd0;
            deb_cnt   <= '0;
            acc       <= 3'd0;
        end else if (cand != last_cand) begin
            last_cand <= cand;
            deb_cnt   <= DW'(1);
            if (DEB_CYCLES == 1) acc <= cand;
        end else if (deb_cnt != DW'(DEB_CYCLES)) begin
            deb_cnt <= deb_cnt + DW'(1);
            if (deb_cnt == DW'(DEB_CYCLES - 1)) acc <= cand;
        end
    end

    assign man_oct   = sw_s2[2] ? 2'd3 : sw_s2[1] ? 2'd2 : sw_s2[0] ? 2'd1 : 2'd0;
    assign idx_inc   = Song_Idx + 5'd1;
    assign dbg_state = state;

    // Next state, song position, note timer and the note request for the next cycle.
    always_comb begin
        state_n = state;
        idx_n   = Song_Idx;
        tmr_n   = tmr;
        start_n = 1'b0;
        entry_n = 8'd0;
        valid_n = 1'b0;
        code_n  = 3'd0;
        oct_n   = 2'd0;
        hp_n    = 16'd0;
        if (sw_s2[3]) begin
            case (state)
                AUTO_PLAY: begin
                    if (tmr == 32'd0) begin
                        state_n = AUTO_GAP;
                        tmr_n   = 32'(GAP_CYCLES - 1);
                    end else begin
                        tmr_n = tmr - 32'd1;
                    end
                end
                AUTO_GAP: begin
                    if (tmr == 32'd0) begin
                        state_n = AUTO_PLAY;
                        start_n = 1'b1;
                        // End marker (or running off index 31) loops straight back to idx0.
                        idx_n   = ((rom_entry(idx_inc) & 8'h07) == 8'h00) ? 5'd0 : idx_inc;
                    end else begin
                        tmr_n = tmr - 32'd1;
                    end
                end
                default: begin
                    state_n = AUTO_PLAY;
                    start_n = 1'b1;
                    idx_n   = 5'd0;
                end
            endcase
        end else if (sw_s2[2:0] != 3'd0) begin
            state_n = MANUAL;
        end else begin
            state_n = IDLE;
        end
        entry_n = rom_entry(idx_n);
        if (start_n) tmr_n = play_len(entry_n[2:0]);
        case (state_n)
            MANUAL: begin
                if (acc != 3'd0) begin
                    valid_n = 1'b1;
                    code_n  = acc;
                    oct_n   = man_oct;
                    hp_n    = hp_for(acc, man_oct);
                end
            end
            AUTO_PLAY: begin
                if (entry_n[5:3] != 3'd0) begin
                    valid_n = 1'b1;
                    code_n  = entry_n[5:3];
                    oct_n   = entry_n[7:6];
                    hp_n    = hp_for(entry_n[5:3], entry_n[7:6]);
                end
            end
            default: ;
        endcase
    end

    // State and registered note request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            tmr         <= 32'd0;
            Song_Idx    <= 5'd0;
            Note_Start  <= 1'b0;
            Note_Valid  <= 1'b0;
            Note_Code   <= 3'd0;
            Octave      <= 2'd0;
            Half_Period <= 16'd0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            Song_Idx    <= idx_n;
            Note_Start  <= start_n;
            Note_Valid  <= valid_n;
            Note_Code   <= code_n;
            Octave      <= oct_n;
            Half_Period <= hp_n;
        end
    end
endmodule

// File: tb/tb_piano_play_scheduler.sv
// Bench for piano_play_scheduler: directed steps plus randomized keys/switches,
// compared each cycle against a pin-history reference model.
module tb_piano_play_scheduler;
    localparam int CLK_HZ = 1_000_000;
    localparam int DEB    = 4;
    localparam int BEAT   = 40;
    localparam int GAP    = 8;
    localparam int SONG_LEN = 14;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  Switch = 4'd0;
    logic [6:0]  Key = 7'd0;
    logic        Note_Valid;
    logic [2:0]  Note_Code;
    logic [1:0]  Octave;
    logic [15:0] Half_Period;
    logic [4:0]  Song_Idx;
    logic        Note_Start;
    logic [1:0]  dbg_state;

    piano_play_scheduler #(
        .CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)
    ) dut (
        .CLK(CLK), .RST(RST), .Switch(Switch), .Key(Key),
        .Note_Valid(Note_Valid), .Note_Code(Note_Code), .Octave(Octave),
        .Half_Period(Half_Period), .Song_Idx(Song_Idx), .Note_Start(Note_Start),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial forever #5 CLK = ~CLK;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard and reference model state
    int          n_checks = 0;
    int          n_fail = 0;
    logic [29:0] exp_q[$];
    logic [3:0]  sw_h[$];
    logic [2:0]  cand_h[$];
    int          edge_n = -1;
    int          last_rst = -1;
    bit          in_auto = 1'b0;
    int          entry_edge = 0;
    int          last_idx = 0;
    int          song_cycles = 0;
    int          song_note[SONG_LEN]  = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1};
    int          song_beats[SONG_LEN] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};
    int          freq[7] = '{262, 294, 330, 349, 392, 440, 494};

    function automatic int key_code(input logic [6:0] k);
        for (int i = 6; i >= 0; i--) if (k[i]) return 7 - i;
        return 0;
    endfunction

    function automatic int ref_hp(input int code, input int oct);
        int mid;
        mid = CLK_HZ / (2 * freq[code - 1]);
        if (oct == 1) return mid * 2;
        if (oct == 3) return mid / 2;
        return mid;
    endfunction

    function automatic logic [3:0] sw_at(input int i);
        if (i < 0 || i <= last_rst) return 4'd0;
        return sw_h[i];
    endfunction

    // Accepted key after edge j: the most recent run of DEB equal candidates seen by the core.
    function automatic int acc_after(input int j);
        bit same;
        for (int m = j - 2; (m - DEB + 1 > last_rst) && (m - DEB + 1 >= 0); m--) begin
            same = 1'b1;
            for (int q = m - DEB + 1; q < m; q++) if (cand_h[q] != cand_h[m]) same = 1'b0;
            if (same) return int'(cand_h[m]);
        end
        return 0;
    endfunction

    task automatic model_edge();
        logic [3:0] swv;
        int st, idx, start, valid, code, oct, hp, t, a;
        edge_n++;
        if (RST) begin
            sw_h.push_back(4'd0);
            cand_h.push_back(3'd0);
            last_rst = edge_n;
            in_auto  = 1'b0;
            last_idx = 0;
            exp_q.push_back(30'd0);
            return;
        end
        sw_h.push_back(Switch);
        cand_h.push_back(3'(key_code(Key)));
        swv = sw_at(edge_n - 2);
        valid = 0; code = 0; oct = 0; hp = 0; start = 0; st = 0; idx = last_idx;
        if (swv[3]) begin
            if (!in_auto) begin
                in_auto    = 1'b1;
                entry_edge = edge_n;
            end
            t = (edge_n - entry_edge) % song_cycles;
            idx = 0;
            while (t >= song_beats[idx] * BEAT) begin
                t -= song_beats[idx] * BEAT;
                idx++;
            end
            start = (t == 0) ? 1 : 0;
            if (t < song_beats[idx] * BEAT - GAP) begin
                st = 2;
                if (song_note[idx] != 0) begin
                    valid = 1; code = song_note[idx]; oct = 2; hp = ref_hp(code, oct);
                end
            end else begin
                st = 3;
            end
            last_idx = idx;
        end else begin
            in_auto = 1'b0;
            if (swv[2:0] != 3'd0) begin
                st = 1;
                a = acc_after(edge_n - 1);
                if (a != 0) begin
                    valid = 1; code = a;
                    oct = swv[2] ? 3 : swv[1] ? 2 : 1;
                    hp = ref_hp(a, oct);
                end
            end
        end
        exp_q.push_back({1'(valid), 3'(code), 2'(oct), 16'(hp), 5'(idx), 1'(start), 2'(st)});
    endtask

    // Driver tasks
    task automatic tick();
        logic [29:0] obs, expv;
        @(posedge CLK);
        model_edge();
        #1;
        obs  = {Note_Valid, Note_Code, Octave, Half_Period, Song_Idx, Note_Start, dbg_state};
        expv = exp_q.pop_front();
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL cycle@%0d observed=%h expected=%h", edge_n, obs, expv);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tick_rk();
        Key = 7'($urandom_range(0, 127));
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_start(input string tag, input int limit);
        int k;
        k = 0;
        while (Note_Start !== 1'b1 && k < limit) begin
            tick_rk();
            k++;
        end
        check(tag, 32'(Note_Start), 32'd1);
    endtask

    initial begin
        int cnt, k;
        for (int i = 0; i < SONG_LEN; i++) song_cycles += song_beats[i] * BEAT;

        // 1: reset, then IDLE ignores keys
        ticks(3);
        check("reset_valid", 32'(Note_Valid), 32'd0);
        check("reset_idx", 32'(Song_Idx), 32'd0);
        RST = 1'b0;
        Key = 7'b1000000;
        ticks(20);
        check("idle_state", 32'(dbg_state), 32'd0);
        check("idle_hp", 32'(Half_Period), 32'd0);

        // 2: mid octave, do, press/release latency
        Key = 7'd0;
        ticks(8);
        Switch = 4'b0010;
        ticks(5);
        check("manual_state", 32'(dbg_state), 32'd1);
        Key = 7'b1000000;
        ticks(6);
        check("press_not_yet", 32'(Note_Valid), 32'd0);
        tick();
        check("press_code", 32'(Note_Code), 32'd1);
        check("press_oct", 32'(Octave), 32'd2);
        check("press_hp", 32'(Half_Period), 32'd1908);
        Key = 7'd0;
        ticks(6);
        check("release_not_yet", 32'(Note_Valid), 32'd1);
        tick();
        check("release_silent", 32'(Note_Valid), 32'd0);

        // 3: low octave, priority, glitch rejection, octave change
        Switch = 4'b0001;
        Key = 7'b0100100;
        ticks(10);
        check("low_code", 32'(Note_Code), 32'd2);
        check("low_hp", 32'(Half_Period), 32'd3400);
        Key = 7'b0000100;
        ticks(2);
        Key = 7'b0100100;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("glitch_hold", 32'(Note_Code), 32'd2);
        end
        Switch = 4'b0100;
        ticks(2);
        check("oct_not_yet", 32'(Half_Period), 32'd3400);
        tick();
        check("high_hp", 32'(Half_Period), 32'd850);
        check("high_oct", 32'(Octave), 32'd3);

        // Random manual play
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 2) == 0) Key = 7'd0;
            else Key = 7'($urandom_range(1, 127));
            if ($urandom_range(0, 4) == 0) Switch = 4'($urandom_range(1, 7));
            ticks($urandom_range(1, 9));
        end

        // 4: auto-play timing and wrap
        Switch = 4'b1000;
        wait_start("auto_entry", 6);
        check("auto_idx0", 32'(Song_Idx), 32'd0);
        cnt = 0;
        while (Note_Valid === 1'b1 && cnt < 200) begin cnt++; tick_rk(); end
        check("idx0_play_len", 32'(cnt), 32'd32);
        cnt = 0;
        while (Note_Valid === 1'b0 && Note_Start === 1'b0 && cnt < 200) begin cnt++; tick_rk(); end
        check("idx0_gap_len", 32'(cnt), 32'd8);
        check("idx1_start", 32'(Note_Start), 32'd1);
        check("idx1_idx", 32'(Song_Idx), 32'd1);
        k = 0;
        while (Song_Idx !== 5'd6 && k < 400) begin k++; tick_rk(); end
        cnt = 0;
        while (Note_Valid === 1'b1 && cnt < 200) begin cnt++; tick_rk(); end
        check("idx6_play_len", 32'(cnt), 32'd72);
        k = 0;
        while (Song_Idx !== 5'd13 && k < 600) begin k++; tick_rk(); end
        k = 0;
        while (Song_Idx === 5'd13 && k < 200) begin k++; tick_rk(); end
        check("wrap_idx", 32'(Song_Idx), 32'd0);
        check("wrap_start", 32'(Note_Start), 32'd1);

        // 5: auto beats manual switches; leaving auto mid-note
        Switch = 4'b1011;
        for (int i = 0; i < 30; i++) tick_rk();
        Key = 7'd0;
        ticks(10);
        wait_start("auto_again", 400);
        ticks(2);
        Switch = 4'b0010;
        ticks(2);
        check("leave_not_yet", 32'(Note_Valid), 32'd1);
        tick();
        check("leave_silent", 32'(Note_Valid), 32'd0);
        check("leave_manual", 32'(dbg_state), 32'd1);

        // 6: reset in the middle of idx5, auto restarts from idx0
        Switch = 4'b1000;
        k = 0;
        while (!(Song_Idx === 5'd5 && Note_Valid === 1'b1) && k < 600) begin k++; tick(); end
        check("reach_idx5", 32'(Song_Idx), 32'd5);
        ticks(3);
        RST = 1'b1;
        #1;
        check("async_rst_out", 32'({Note_Valid, Note_Code, Octave, Half_Period, Song_Idx, Note_Start}), 32'd0);
        ticks(2);
        RST = 1'b0;
        ticks(2);
        check("rst_no_start_yet", 32'(Note_Start), 32'd0);
        tick();
        check("rst_restart", 32'(Note_Start), 32'd1);
        check("rst_restart_idx", 32'(Song_Idx), 32'd0);
        check("rst_restart_hp", 32'(Half_Period), 32'd1908);

        // Random mode and key mix
        for (int i = 0; i < 40; i++) begin
            Switch = 4'($urandom_range(0, 15));
            cnt = $urandom_range(1, 60);
            for (int j = 0; j < cnt; j++) begin
                if ($urandom_range(0, 3) == 0) Key = 7'($urandom_range(0, 127));
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
